closest_hit_scheduler: RTL and testbench

Sequences one ray against a contiguous list of triangles through the shared `intersection` datapath and reports the closest hit. Triangles are read from a synchronous triangle memory and issued back-to-back, one per cycle, under a credit limit. The block sits between the ray dispatcher and the `intersection` unit. All arithmetic values are signed Q16.16.

---
 rtl/closest_hit_scheduler.sv | 167 ++++++++++++++++
 tb/tb_closest_hit_scheduler.sv | 436 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/closest_hit_scheduler.sv
// closest_hit_scheduler: streams one ray against a contiguous triangle list
// through the shared intersection unit and reports the closest hit.
//
// Ports:
//   i_clk, i_rst             clock, synchronous active-high reset
//   i_start, i_ray,          start pulse (accepted while o_busy=0) with the
//   i_base, i_num_tri        ray, first triangle address and triangle count
//   o_busy                   ray in progress, through the o_done cycle
//   o_mem_rd, o_mem_addr     triangle memory read port
//   i_mem_data               triangle vertices, valid 1 cycle after o_mem_rd
//   o_int_en, o_int_tri,     issue port to the intersection unit
//   o_int_ray
//   i_int_valid,             in-order results from the intersection unit
//   i_int_result, i_int_t
//   o_done, o_hit, o_t,      final result; held until the next ray's done
//   o_tri_idx
module closest_hit_scheduler #(
  parameter int IDX_W        = 10,
  parameter int MAX_INFLIGHT = 16
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_start,
  input  logic [1:0][2:0][31:0]    i_ray,
  input  logic [IDX_W-1:0]         i_base,
  input  logic [IDX_W-1:0]         i_num_tri,
  output logic                     o_busy,
  output logic                     o_mem_rd,
  output logic [IDX_W-1:0]         o_mem_addr,
  input  logic [2:0][2:0][31:0]    i_mem_data,
  output logic                     o_int_en,
  output logic [2:0][2:0][31:0]    o_int_tri,
  output logic [1:0][2:0][31:0]    o_int_ray,
  input  logic                     i_int_valid,
  input  logic                     i_int_result,
  input  logic signed [31:0]       i_int_t,
  output logic                     o_done,
  output logic                     o_hit,
  output logic signed [31:0]       o_t,
  output logic [IDX_W-1:0]         o_tri_idx
);

  localparam int CW = $clog2(MAX_INFLIGHT) + 1;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN,
    DONE
  } state_e;

  state_e                 state_q;
  logic [IDX_W-1:0]       base_q;
  logic [IDX_W-1:0]       num_q;
  logic [IDX_W-1:0]       issue_q;
  logic [IDX_W-1:0]       ret_q;
  logic [IDX_W-1:0]       best_idx_q;
  logic signed [31:0]     best_t_q;
  logic                   hit_q;
  logic [CW-1:0]          infl_q;

  logic can_issue;
  logic ret_ok;
  logic better;

  // A read is launched only while the credit window has room; the credit
  // is taken at the read so the memory latency is covered by the limit.
  assign can_issue = (state_q == ISSUE)
                   && (issue_q < num_q)
                   && (infl_q < CW'(MAX_INFLIGHT));

  // Results outside an active ray belong to an abandoned ray.
  assign ret_ok = i_int_valid
                && ((state_q == ISSUE) || (state_q == DRAIN));

  // Strict less-than keeps the earlier index on equal distances.
  assign better = i_int_result
                && (!hit_q || (i_int_t < best_t_q));

  // The synchronous memory output is the triangle register feeding the
  // intersection unit; it lines up with o_int_en by construction.
  assign o_int_tri = i_mem_data;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= IDLE;
      base_q     <= '0;
      num_q      <= '0;
      issue_q    <= '0;
      ret_q      <= '0;
      best_idx_q <= '0;
      best_t_q   <= '0;
      hit_q      <= 1'b0;
      infl_q     <= '0;
      o_busy     <= 1'b0;
      o_mem_rd   <= 1'b0;
      o_mem_addr <= '0;
      o_int_en   <= 1'b0;
      o_int_ray  <= '0;
      o_done     <= 1'b0;
      o_hit      <= 1'b0;
      o_t        <= '0;
      o_tri_idx  <= '0;
    end else begin
      o_done   <= 1'b0;
      o_mem_rd <= 1'b0;
      o_int_en <= o_mem_rd;

      infl_q <= infl_q
              + {{(CW-1){1'b0}}, can_issue}
              - {{(CW-1){1'b0}}, ret_ok};

      if (ret_ok) begin
        ret_q <= ret_q + IDX_W'(1);
        if (better) begin
          best_t_q   <= i_int_t;
          best_idx_q <= ret_q;
          hit_q      <= 1'b1;
        end
      end

      unique case (state_q)
        IDLE: begin
          // o_done is high in the first IDLE cycle: busy ends there.
          if (o_done) begin
            o_busy <= 1'b0;
          end
          if (i_start && !o_busy) begin
            o_int_ray  <= i_ray;
            base_q     <= i_base;
            num_q      <= i_num_tri;
            issue_q    <= '0;
            ret_q      <= '0;
            infl_q     <= '0;
            best_idx_q <= '0;
            best_t_q   <= '0;
            hit_q      <= 1'b0;
            o_busy     <= 1'b1;
            state_q    <= (i_num_tri != '0) ? ISSUE : DONE;
          end
        end
        ISSUE: begin
          if (can_issue) begin
            o_mem_rd   <= 1'b1;
            o_mem_addr <= base_q + issue_q;
            issue_q    <= issue_q + IDX_W'(1);
          end else if (issue_q == num_q) begin
            state_q <= DRAIN;
          end
        end
        DRAIN: begin
          if (ret_q == num_q) begin
            state_q <= DONE;
          end
        end
        DONE: begin
          o_done    <= 1'b1;
          o_hit     <= hit_q;
          o_t       <= hit_q ? best_t_q : '0;
          o_tri_idx <= hit_q ? best_idx_q : '0;
          state_q   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_closest_hit_scheduler.sv
// tb_closest_hit_scheduler: randomized self-checking bench with a
// behavioural triangle memory, intersection model and closest-hit reference.
module tb_closest_hit_scheduler;

  typedef logic [1:0][2:0][31:0] ray_t;
  typedef logic [2:0][2:0][31:0] tri_t;
  typedef logic [2:0][31:0]      vec_t;

  typedef struct {
    int                 due;
    logic               hit;
    logic signed [31:0] t;
  } res_s;

  logic               clk;
  logic               i_rst;
  logic               i_start;
  ray_t               i_ray;
  logic [9:0]         i_base;
  logic [9:0]         i_num_tri;
  logic               o_busy;
  logic               o_mem_rd;
  logic [9:0]         o_mem_addr;
  tri_t               mem_data;
  logic               o_int_en;
  tri_t               o_int_tri;
  ray_t               o_int_ray;
  logic               iv;
  logic               ir;
  logic signed [31:0] it;
  logic               o_done;
  logic               o_hit;
  logic signed [31:0] o_t;
  logic [9:0]         o_tri_idx;

  closest_hit_scheduler #(
    .IDX_W(10),
    .MAX_INFLIGHT(16)
  ) dut (
    .i_clk(clk),
    .i_rst(i_rst),
    .i_start(i_start),
    .i_ray(i_ray),
    .i_base(i_base),
    .i_num_tri(i_num_tri),
    .o_busy(o_busy),
    .o_mem_rd(o_mem_rd),
    .o_mem_addr(o_mem_addr),
    .i_mem_data(mem_data),
    .o_int_en(o_int_en),
    .o_int_tri(o_int_tri),
    .o_int_ray(o_int_ray),
    .i_int_valid(iv),
    .i_int_result(ir),
    .i_int_t(it),
    .o_done(o_done),
    .o_hit(o_hit),
    .o_t(o_t),
    .o_tri_idx(o_tri_idx)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  tri_t               tmem    [1024];
  logic               res_hit [1024];
  logic signed [31:0] res_t   [1024];

  res_s       resq[$];
  int         addrq[$];
  int         addr_log[$];
  int         cyc = 0;
  int         lat_cur = 1;
  ray_t       cur_ray;
  int         rd_cnt, en_cnt, infl, max_inf, tri_err, ray_err;
  int         tests = 0;
  int         fails = 0;

  // Synchronous triangle memory and fixed-latency in-order intersection unit.
  always @(posedge clk) begin
    cyc++;
    if (o_mem_rd) mem_data <= tmem[o_mem_addr];
    if (resq.size() > 0 && resq[0].due <= cyc) begin
      res_s r;
      r = resq.pop_front();
      iv <= 1'b1;
      ir <= r.hit;
      it <= r.t;
    end else begin
      iv <= 1'b0;
      ir <= 1'b0;
      it <= '0;
    end
  end

  // Observer: counts traffic, tracks credits, checks issued data.
  always @(negedge clk) begin
    int a;
    if (o_int_en) begin
      en_cnt++;
      a = 0;
      if (addrq.size() == 0) tri_err++;
      else a = addrq.pop_front();
      if (o_int_tri !== tmem[a]) tri_err++;
      if (o_int_ray !== cur_ray) ray_err++;
      resq.push_back('{due: cyc + lat_cur, hit: res_hit[a], t: res_t[a]});
    end
    if (o_mem_rd) begin
      rd_cnt++;
      infl++;
      addrq.push_back(int'(o_mem_addr));
      addr_log.push_back(int'(o_mem_addr));
    end
    if (iv) infl--;
    if (infl > max_inf) max_inf = infl;
  end

  function automatic vec_t v3(int x2, int y2, int z2);
    vec_t v;
    v[0] = 32'(x2 * 32'h8000);
    v[1] = 32'(y2 * 32'h8000);
    v[2] = 32'(z2 * 32'h8000);
    return v;
  endfunction

  // Closest hit by definition: smallest t among hits, earliest on ties.
  function automatic void ref_closest(input int base, input int n,
                                      output logic h,
                                      output logic signed [31:0] t,
                                      output int idx);
    h = 0;
    t = 0;
    idx = 0;
    for (int i = 0; i < n; i++) begin
      int a;
      a = (base + i) % 1024;
      if (res_hit[a] && (!h || res_t[a] < t)) begin
        h = 1;
        t = res_t[a];
        idx = i;
      end
    end
  endfunction

  task automatic do_reset();
    @(negedge clk);
    i_rst = 1;
    i_start = 0;
    @(posedge clk);
    #1;
    resq.delete();
    addrq.delete();
    infl = 0;
    repeat (2) @(negedge clk);
    i_rst = 0;
  endtask

  task automatic run_ray(input ray_t ray, input int base, input int n,
                         input int lat, input int poke,
                         output int dlat, output logic h,
                         output logic signed [31:0] t, output int idx);
    int k;
    @(posedge clk);
    #1;
    cur_ray = ray;
    lat_cur = lat;
    rd_cnt = 0;
    en_cnt = 0;
    infl = 0;
    max_inf = 0;
    tri_err = 0;
    ray_err = 0;
    addr_log.delete();
    @(negedge clk);
    i_start = 1;
    i_ray = ray;
    i_base = 10'(base);
    i_num_tri = 10'(n);
    @(negedge clk);
    i_start = 0;
    k = 1;
    while (!o_done && k < 3000) begin
      @(negedge clk);
      k++;
      i_start = 0;
      if (k == poke) begin
        i_start = 1;
        i_base = 10'd0;
        i_num_tri = 10'd5;
      end
    end
    i_start = 0;
    tests++;
    if (!o_done) begin
      fails++;
      $display("FAIL done_timeout base=%0d n=%0d: no o_done in %0d cycles",
               base, n, k);
      dlat = -1;
    end else begin
      dlat = k;
    end
    h = o_hit;
    t = o_t;
    idx = int'(o_tri_idx);
  endtask

  task automatic check_res(input string name, input logic h,
                           input logic signed [31:0] t, input int idx,
                           input logic eh, input logic signed [31:0] et,
                           input int eidx);
    tests++;
    if (h !== eh || t !== et || idx != eidx) begin
      fails++;
      $display("FAIL %s: got hit=%0b t=%h idx=%0d, want hit=%0b t=%h idx=%0d",
               name, h, t, idx, eh, et, eidx);
    end
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    tests++;
    if ({o_busy, o_mem_rd, o_int_en, o_done, o_hit, o_t, o_tri_idx,
         o_mem_addr, o_int_ray} !== '0) begin
      fails++;
      $display("FAIL reset_outputs: busy=%0b rd=%0b en=%0b done=%0b hit=%0b t=%h, want all 0",
               o_busy, o_mem_rd, o_int_en, o_done, o_hit, o_t);
    end
  endtask

  task automatic test_single();
    ray_t r;
    int dl, idx;
    logic h;
    logic signed [31:0] t;
    tmem[0] = {v3(2, 2, 6), v3(4, 6, 4), v3(2, 2, 2)};
    res_hit[0] = 1;
    res_t[0] = 32'h0002C000;
    r = {v3(6, 1, 3), v3(0, 2, 2)};
    run_ray(r, 0, 1, 3, 0, dl, h, t, idx);
    check_res("single", h, t, idx, 1'b1, 32'h0002C000, 0);
    tests++;
    if (en_cnt != 1 || tri_err != 0 || ray_err != 0) begin
      fails++;
      $display("FAIL single_issue: en=%0d tri_err=%0d ray_err=%0d, want 1/0/0",
               en_cnt, tri_err, ray_err);
    end
  endtask

  task automatic test_three();
    ray_t r;
    int dl, idx;
    logic h;
    logic signed [31:0] t;
    tmem[0] = {v3(4, 4, 0), v3(-4, 4, 0), v3(0, 4, 0)};
    tmem[1] = {v3(4, -4, 0), v3(-4, -4, 0), v3(0, 4, 0)};
    tmem[2] = {v3(2, 2, 6), v3(4, 6, 4), v3(2, 2, 2)};
    res_hit[0] = 0;
    res_t[0] = 32'h7FFFFFFF;
    res_hit[1] = 1;
    res_t[1] = 32'h00010000;
    res_hit[2] = 1;
    res_t[2] = 32'h0002C000;
    r = {v3(0, 0, -2), v3(0, 0, 2)};
    run_ray(r, 0, 3, 4, 0, dl, h, t, idx);
    check_res("three", h, t, idx, 1'b1, 32'h00010000, 1);
  endtask

  task automatic test_zero();
    int dl, idx;
    logic h;
    logic signed [31:0] t;
    run_ray(ray_t'(0), 7, 0, 2, 0, dl, h, t, idx);
    check_res("zero", h, t, idx, 1'b0, 32'sd0, 0);
    tests++;
    if (dl != 2 || rd_cnt != 0) begin
      fails++;
      $display("FAIL zero_timing: done after %0d reads=%0d, want 2/0",
               dl, rd_cnt);
    end
  endtask

  task automatic test_inflight();
    int dl, idx;
    logic h, eh;
    logic signed [31:0] t, et;
    int eidx;
    for (int i = 0; i < 40; i++) begin
      res_hit[100 + i] = 1;
      res_t[100 + i] = 32'h50000 + 32'($urandom_range(0, 32'hFFFF));
    end
    res_t[105] = 32'h100;
    res_t[130] = 32'h100;
    ref_closest(100, 40, eh, et, eidx);
    run_ray(ray_t'({6{$urandom}}), 100, 40, 20, 0, dl, h, t, idx);
    check_res("inflight_tie", h, t, idx, eh, et, eidx);
    check_res("inflight_tie_const", h, t, idx, 1'b1, 32'h100, 5);
    tests++;
    if (max_inf != 16 || en_cnt != 40 || tri_err != 0 || ray_err != 0) begin
      fails++;
      $display("FAIL inflight_limit: max=%0d en=%0d terr=%0d rerr=%0d, want 16/40/0/0",
               max_inf, en_cnt, tri_err, ray_err);
    end
  endtask

  task automatic test_reset_mid();
    int dl, idx, k;
    logic h, eh;
    logic signed [31:0] t, et;
    int eidx;
    for (int i = 0; i < 12; i++) begin
      res_hit[300 + i] = 1;
      res_t[300 + i] = 32'h1000;
    end
    @(negedge clk);
    i_start = 1;
    i_base = 10'd300;
    i_num_tri = 10'd12;
    lat_cur = 30;
    @(negedge clk);
    i_start = 0;
    k = 0;
    while (!(o_busy && rd_cnt >= 12 && !o_int_en) && k < 200) begin
      @(negedge clk);
      k++;
    end
    repeat (3) @(negedge clk);
    do_reset();
    @(posedge clk);
    #1;
    for (int i = 1; i <= 3; i++)
      resq.push_back('{due: cyc + i, hit: 1'b1, t: 32'sh80000000});
    repeat (6) @(negedge clk);
    tests++;
    if (o_busy !== 1'b0 || o_done !== 1'b0 || o_hit !== 1'b0) begin
      fails++;
      $display("FAIL reset_mid_idle: busy=%0b done=%0b hit=%0b, want 0/0/0",
               o_busy, o_done, o_hit);
    end
    res_hit[200] = 1;
    res_t[200] = 32'h30000;
    res_hit[201] = 1;
    res_t[201] = 32'h20000;
    ref_closest(200, 2, eh, et, eidx);
    run_ray(ray_t'({6{$urandom}}), 200, 2, 5, 0, dl, h, t, idx);
    check_res("reset_mid_new", h, t, idx, eh, et, eidx);
  endtask

  task automatic test_busy_wrap();
    int dl, idx;
    logic h, eh;
    logic signed [31:0] t, et;
    int eidx;
    tmem[1023] = tri_t'({9{$urandom}});
    res_hit[1023] = 1;
    res_t[1023] = 32'h40000;
    res_hit[0] = 1;
    res_t[0] = 32'hFFFF0000;
    res_hit[1] = 0;
    ref_closest(1023, 3, eh, et, eidx);
    run_ray(ray_t'({6{$urandom}}), 1023, 3, 3, 2, dl, h, t, idx);
    check_res("busy_wrap", h, t, idx, eh, et, eidx);
    tests++;
    if (addr_log.size() != 3 || addr_log[0] != 1023
        || addr_log[1] != 0 || addr_log[2] != 1) begin
      fails++;
      $display("FAIL wrap_addr: %0d reads first=%0d, want 3 reads 1023,0,1",
               addr_log.size(), addr_log.size() > 0 ? addr_log[0] : -1);
    end
    repeat (6) @(negedge clk);
    tests++;
    if (o_busy !== 1'b0 || rd_cnt != 3 || tri_err != 0) begin
      fails++;
      $display("FAIL busy_ignore: busy=%0b reads=%0d terr=%0d, want 0/3/0",
               o_busy, rd_cnt, tri_err);
    end
  endtask

  task automatic test_random();
    for (int r = 0; r < 8; r++) begin
      int dl, idx, base, n, lat;
      logic h, eh;
      logic signed [31:0] t, et;
      int eidx;
      base = $urandom_range(0, 1023);
      n = $urandom_range(1, 40);
      lat = $urandom_range(1, 25);
      for (int i = 0; i < n; i++) begin
        int a;
        a = (base + i) % 1024;
        tmem[a] = tri_t'({9{$urandom}});
        res_hit[a] = ($urandom_range(0, 1) == 1);
        res_t[a] = 32'(($urandom_range(0, 15) - 8) * 32'h10000);
      end
      ref_closest(base, n, eh, et, eidx);
      run_ray(ray_t'({6{$urandom}}), base, n, lat, 0, dl, h, t, idx);
      check_res("random", h, t, idx, eh, et, eidx);
      tests++;
      if (en_cnt != n || max_inf > 16 || tri_err != 0 || ray_err != 0) begin
        fails++;
        $display("FAIL random_issue: en=%0d n=%0d max=%0d terr=%0d rerr=%0d",
                 en_cnt, n, max_inf, tri_err, ray_err);
      end
    end
  endtask

  initial begin
    i_rst = 1;
    i_start = 0;
    i_ray = '0;
    i_base = '0;
    i_num_tri = '0;
    mem_data = '0;
    iv = 0;
    ir = 0;
    it = 0;
    for (int i = 0; i < 1024; i++) begin
      tmem[i] = tri_t'({9{$urandom}});
      res_hit[i] = 0;
      res_t[i] = 0;
    end
    test_reset();
    test_single();
    test_three();
    test_zero();
    test_inflight();
    test_reset_mid();
    test_busy_wrap();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
